// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel-strobe divider, h/v counters, sync/blank decode
// with a configurable pixel-stage delay, line/frame start pulses and a frame counter.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned CLK_DIV  = 2,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned PIPE     = 1,
    parameter int unsigned CW       = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          pix_en,
    output logic          vga_clk,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic          bright,
    output logic          hsync,
    output logic          vsync,
    output logic          vga_blank_n,
    output logic          line_start,
    output logic          frame_start,
    output logic [7:0]    frame_cnt
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC - 1;
    localparam int unsigned DW       = $clog2(CLK_DIV);

    // Inactive {hsync, vsync, blank_n}: used by reset and every delay stage
    localparam logic [2:0] IDLE_SIG = {~SYNC_POL, ~SYNC_POL, 1'b0};

    logic [DW-1:0] div_cnt;
    logic          h_last;
    logic          v_last;
    logic          hs_raw;
    logic          vs_raw;
    logic [2:0]    raw;

    // Strobe and DAC clock decoded from the divider register; vga_clk rises mid-pixel
    assign pix_en  = en && (div_cnt == DW'(CLK_DIV - 1));
    assign vga_clk = (div_cnt >= DW'(CLK_DIV / 2));

    assign h_last = (hcount == CW'(H_TOTAL - 1));
    assign v_last = (vcount == CW'(V_TOTAL - 1));

    // Undelayed decode of the current counter position
    assign bright = (hcount < CW'(H_ACTIVE)) && (vcount < CW'(V_ACTIVE));
    assign hs_raw = ((hcount >= CW'(HS_START)) && (hcount <= CW'(HS_END))) ? SYNC_POL : ~SYNC_POL;
    assign vs_raw = ((vcount >= CW'(VS_START)) && (vcount <= CW'(VS_END))) ? SYNC_POL : ~SYNC_POL;
    assign raw    = {hs_raw, vs_raw, bright};

    // Divider, pixel/line counters, frame counter and start pulses
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt     <= '0;
            hcount      <= '0;
            vcount      <= '0;
            frame_cnt   <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (en) begin
                div_cnt <= (div_cnt == DW'(CLK_DIV - 1)) ? '0 : div_cnt + DW'(1);
            end
            if (pix_en) begin
                if (h_last) begin
                    hcount     <= '0;
                    line_start <= 1'b1;
                    if (v_last) begin
                        vcount      <= '0;
                        frame_start <= 1'b1;
                        frame_cnt   <= frame_cnt + 8'd1;
                    end else begin
                        vcount <= vcount + CW'(1);
                    end
                end else begin
                    hcount <= hcount + CW'(1);
                end
            end
        end
    end

    generate
        if (PIPE == 0) begin : g_nopipe
            assign {hsync, vsync, vga_blank_n} = raw;
        end else begin : g_pipe
            localparam int unsigned SW = 3 * PIPE;
            logic [SW-1:0] stage;

            // Pixel-rate shift register keeping sync/blank aligned with downstream latency
            always_ff @(posedge clk) begin
                if (!rst) begin
                    stage <= {PIPE{IDLE_SIG}};
                end else if (pix_en) begin
                    stage <= SW'({stage, raw});
                end
            end

            assign {hsync, vsync, vga_blank_n} = stage[SW-1 -: 3];
        end
    endgenerate

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA timing path in the display subsystem.
- Generates the pixel strobe, vga_clk, hcount/vcount, and hsync/vsync/vga_blank_n for any mode.
- Sync and blank outputs are delayed by a configurable number of pixel stages, so they stay aligned with glyph-ROM/bitgen latency downstream.
- Adds enable/freeze, frame/line start pulses and a frame counter; the fixed-mode block has none of these.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
CLK_DIV, 2, clk cycles per pixel; must be even and >=2
SYNC_POL, 0, 0 = sync pulses active-low, 1 = active-high
PIPE, 1, pixel-stage delay on hsync/vsync/vga_blank_n, range 0..4
CW, 10, hcount/vcount width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-low
en  input  1  timing advance enable; low freezes all state
pix_en  output  1  one-clk pixel strobe
vga_clk  output  1  pixel clock to DAC
hcount  output  CW  current pixel column (undelayed)
vcount  output  CW  current line (undelayed)
bright  output  1  hcount<H_ACTIVE && vcount<V_ACTIVE (undelayed)
hsync  output  1  horizontal sync, delayed PIPE pixels
vsync  output  1  vertical sync, delayed PIPE pixels
vga_blank_n  output  1  high in the active area, delayed PIPE pixels
line_start  output  1  one-clk pulse when hcount wraps to 0
frame_start  output  1  one-clk pulse when hcount and vcount both wrap to 0
frame_cnt  output  8  completed-frame counter

Behaviour:
- One clock domain, clk. rst is sampled only on the rising edge of clk; rst=0 resets everything.
- H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL likewise.
- Reset values:
  - div_cnt=0, hcount=0, vcount=0, frame_cnt=0.
  - pix_en=0, line_start=0, frame_start=0, vga_clk=0.
  - hsync and vsync at their inactive level (~SYNC_POL); vga_blank_n=0.
  - All PIPE stages load these same inactive values.
- Divider:
  - div_cnt counts 0..CLK_DIV-1, advancing only when en=1.
  - pix_en = en && div_cnt==CLK_DIV-1 (combinational from registered div_cnt).
  - vga_clk = (div_cnt >= CLK_DIV/2), decoded from the register. Its rising edge falls mid-pixel, so pixel data is stable when sampled.
- Counters:
  - On a clk edge with pix_en=1, hcount increments.
  - At H_TOTAL-1, hcount wraps to 0 and vcount increments.
  - At V_TOTAL-1 (coincident with the hcount wrap), vcount wraps to 0 and frame_cnt increments, modulo 256.
- Raw (undelayed) decode from the counters:
  - hs_raw active for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - vs_raw active for vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
  - blank_raw = bright.
  - Active level is set by SYNC_POL.
- Delay pipeline:
  - PIPE=0: hsync/vsync/vga_blank_n are the raw decode.
  - PIPE>0: a PIPE-deep shift register that shifts only on pix_en. Outputs lag the counters by exactly PIPE pixels.
- Start pulses:
  - line_start is registered, high for exactly one clk: the first cycle after a pix_en edge that wrapped hcount to 0.
  - frame_start is the same, and requires vcount to also wrap to 0.
  - Neither pulse is asserted by reset release. The first frame_start comes at the first natural frame wrap.
- en=0:
  - div_cnt, counters, pipeline and frame_cnt all hold.
  - pix_en=0; vga_clk holds its level.
  - line_start/frame_start deassert after at most one cycle.
  - When en returns to 1, timing resumes with no lost or duplicated pixel.
- Reset mid-frame: the next cycle shows the full reset state, with no pulse on line_start or frame_start.
- Reset has priority over en.

Test Plan:
Bench parameters unless stated: H 8/2/3/3 (H_TOTAL=16), V 4/1/2/1 (V_TOTAL=8), CLK_DIV=2, PIPE=1, SYNC_POL=0.
1. Reset: hold rst=0 for 3 clks -> all outputs at reset values (hsync=vsync=1, blank_n=0). Release -> pix_en on every 2nd clk; hcount 0->1 two clks after release; vga_clk toggles with period 2.
2. Horizontal: hsync low for exactly 6 clks, starting one pixel after hcount=10 and ending one pixel after hcount=12. vga_blank_n high for 16 clks per line within active lines. line_start every 32 clks.
3. Frame: vsync low for 2 lines (64 clks). frame_start period 256 clks. frame_cnt increments per frame and wraps 255->0 after 256 frames.
4. Freeze: drive en=0 for 10 clks at hcount=5 -> hcount, vcount and div_cnt unchanged, pix_en=0. After en=1 -> hcount=6 follows after the normal divider count.
5. Reset mid-frame at hcount=5, vcount=3 -> the next cycle shows reset values. No frame_start until 256 clks after release.
6. Defaults (640x480, CLK_DIV=2) -> H_TOTAL=800, V_TOTAL=525, frame_start period 840000 clks, 640 blank_n-high pixels per active line, hsync low for 96 pixels.
